fifo_wr_ctrl: RTL and testbench
===============================

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 clk_50  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 data_ena  input  1  upstream byte strobe; one byte per high cycle; upstream cannot be stalled.
REQ-005 data_in  input  8  byte value, valid when data_ena=1.
REQ-006 sop  input  1  start-of-packet qualifier, valid when data_ena=1; marks byte 0 of a 4-byte packet.
REQ-007 full_flag  input  1  FIFO cannot accept a write at the next rising edge.
REQ-008 wr_fifo  output  1  registered FIFO write strobe, one cycle per byte.
REQ-009 fifo_data  output  8  registered write data, valid when wr_fifo=1.
REQ-010 byte_cnt  output  2  position (0-3) of the next byte to be written within the current packet.
REQ-011 pkt_done  output  1  registered one-cycle pulse coincident with wr_fifo of packet byte 3.
REQ-012 overflow  output  1  sticky flag: an incoming byte was dropped.
REQ-013 pkt_err  output  1  sticky flag: sop arrived while byte_cnt was not 0.

Function
REQ-014 The block SHALL contain a one-byte hold register and a two-state FSM: EMPTY (hold register invalid) and HELD (hold register valid).
REQ-015 EMPTY, data_ena=1, full_flag=0: next cycle wr_fifo=1, fifo_data=data_in; FSM stays EMPTY; latency 1 cycle.
REQ-016 EMPTY, data_ena=1, full_flag=1: data_in captured into the hold register; wr_fifo=0; FSM goes to HELD.
REQ-017 HELD, full_flag=0, data_ena=0: next cycle wr_fifo=1 with the held byte; FSM goes to EMPTY.
REQ-018 HELD, full_flag=0, data_ena=1: held byte written next cycle; data_in replaces it in the hold register; FSM stays HELD.
REQ-019 HELD, full_flag=1, data_ena=1: data_in dropped; overflow set to 1; hold register unchanged; FSM stays HELD.
REQ-020 HELD, full_flag=1, data_ena=0: no change.
REQ-021 Ordering SHALL be preserved: the held byte is always written before any later byte.
REQ-022 wr_fifo SHALL never be asserted in a cycle following an edge at which full_flag=1.
REQ-023 Each written byte SHALL carry its sop bit through the hold register.
REQ-024 A written byte with sop=1 SHALL be treated as position 0; byte_cnt becomes 1 after that write.
REQ-025 A written byte with sop=0 SHALL increment byte_cnt modulo 4 (3 wraps to 0).
REQ-026 pkt_done SHALL pulse when the written byte occupies position 3, including when sop restarted the count.
REQ-027 A written byte with sop=1 while byte_cnt!=0 SHALL set pkt_err; the packet count realigns to that byte.
REQ-028 Dropped bytes SHALL NOT affect byte_cnt, pkt_done or pkt_err.
REQ-029 overflow and pkt_err SHALL clear only on reset.

Reset
REQ-030 While reset_n=0 at a rising edge: FSM=EMPTY, hold register=0, wr_fifo=0, fifo_data=0x00, byte_cnt=0, pkt_done=0, overflow=0, pkt_err=0.
REQ-031 Reset SHALL take priority over all inputs; a held byte is discarded without a write.
REQ-032 Reset SHALL NOT be sampled asynchronously; an assertion shorter than one edge has no effect.

Verification
REQ-033 Stream: bytes 0xA0(sop)..0xA3, full_flag=0 -> wr_fifo one cycle after each strobe, data A0..A3 in order, pkt_done with A3, byte_cnt 1,2,3,0.
REQ-034 Stall: 0x11 with full_flag=1, then full_flag=0 three cycles later -> no write while full; 0x11 written one cycle after full_flag falls; FSM returns to EMPTY.
REQ-035 Overflow: full_flag=1, strobes 0x21, 0x22 -> 0x21 held, 0x22 dropped, overflow=1; after full_flag=0 only 0x21 is written.
REQ-036 Back-to-back: HELD with 0x31, full_flag=0 and strobe 0x32 in the same cycle -> 0x31 written, then 0x32, FSM stays HELD one cycle, then EMPTY.
REQ-037 Misalignment: sop on 0x40, 0x41, then sop on 0x50 -> pkt_err=1; byte_cnt=1 after 0x50; pkt_done on the 4th byte after 0x50.
REQ-038 Mid-operation reset: HELD with overflow=1, reset_n=0 for one edge -> all outputs at reset values; held byte never written.

Source files
------------

// File: rtl/fifo_wr_ctrl_if.sv
// Byte-stream and FIFO write-side bundle for fifo_wr_ctrl.
// The master drives the upstream strobe, data, sop and full_flag; the slave returns the write strobe and status.
interface fifo_wr_ctrl_if;
  logic       data_ena;
  logic [7:0] data_in;
  logic       sop;
  logic       full_flag;
  logic       wr_fifo;
  logic [7:0] fifo_data;
  logic [1:0] byte_cnt;
  logic       pkt_done;
  logic       overflow;
  logic       pkt_err;

  modport master (
    output data_ena, data_in, sop, full_flag,
    input  wr_fifo, fifo_data, byte_cnt, pkt_done, overflow, pkt_err
  );

  modport slave (
    input  data_ena, data_in, sop, full_flag,
    output wr_fifo, fifo_data, byte_cnt, pkt_done, overflow, pkt_err
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Unstallable byte stream into a FIFO, using a one-byte skid register.
// Also tracks the position within 4-byte packets and keeps sticky overflow and packet-error flags.
module fifo_wr_ctrl (
  input  logic           clk_50,
  input  logic           reset_n,
  fifo_wr_ctrl_if.slave  bus
);

  typedef enum logic {EMPTY, HELD} state_t;

  state_t     state;
  logic [7:0] hold_data;
  logic       hold_sop;

  logic       wr_q;
  logic [7:0] data_q;
  logic [1:0] cnt_q;
  logic       done_q;
  logic       ovf_q;
  logic       err_q;

  logic       do_wr;
  logic [7:0] wr_byte;
  logic       wr_sop;
  logic [1:0] pos;

  // The held byte always has write priority, which keeps bytes in order.
  always_comb begin
    do_wr   = 1'b0;
    wr_byte = hold_data;
    wr_sop  = hold_sop;
    if (state == EMPTY) begin
      do_wr   = bus.data_ena && !bus.full_flag;
      wr_byte = bus.data_in;
      wr_sop  = bus.sop;
    end else begin
      do_wr   = !bus.full_flag;
    end
    pos = wr_sop ? 2'd0 : cnt_q;
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state     <= EMPTY;
      hold_data <= '0;
      hold_sop  <= 1'b0;
      wr_q      <= 1'b0;
      data_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_q   <= do_wr;
      done_q <= do_wr && (pos == 2'd3);
      if (do_wr) begin
        data_q <= wr_byte;
        cnt_q  <= pos + 2'd1;
        if (wr_sop && (cnt_q != 2'd0)) err_q <= 1'b1;
      end
      unique case (state)
        EMPTY: begin
          if (bus.data_ena && bus.full_flag) begin
            hold_data <= bus.data_in;
            hold_sop  <= bus.sop;
            state     <= HELD;
          end
        end
        HELD: begin
          if (!bus.full_flag) begin
            if (bus.data_ena) begin
              hold_data <= bus.data_in;
              hold_sop  <= bus.sop;
            end else begin
              state <= EMPTY;
            end
          end else if (bus.data_ena) begin
            ovf_q <= 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.wr_fifo   = wr_q;
  assign bus.fifo_data = data_q;
  assign bus.byte_cnt  = cnt_q;
  assign bus.pkt_done  = done_q;
  assign bus.overflow  = ovf_q;
  assign bus.pkt_err   = err_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl.
// The expected output vectors {wr_fifo, fifo_data, byte_cnt, pkt_done, overflow, pkt_err} were worked out by hand.
module tb_fifo_wr_ctrl;
  logic clk_50 = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  fifo_wr_ctrl_if bus ();

  fifo_wr_ctrl dut (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #10 clk_50 = ~clk_50;

  logic [13:0] obs;
  assign obs = {bus.wr_fifo, bus.fifo_data, bus.byte_cnt, bus.pkt_done, bus.overflow, bus.pkt_err};

  // Stimulus word layout: {data_ena, sop, full_flag, data_in}
  function automatic logic [10:0] sv(input logic ena, input logic s, input logic full, input logic [7:0] d);
    return {ena, s, full, d};
  endfunction

  function automatic logic [13:0] ev(input logic wr, input logic [7:0] d, input logic [1:0] cnt,
                                     input logic done, input logic ovf, input logic err);
    return {wr, d, cnt, done, ovf, err};
  endfunction

  // fifo_data is only meaningful while the expected wr_fifo is 1.
  function automatic logic [13:0] msk(input logic [13:0] e);
    return e[13] ? 14'h3FFF : 14'h201F;
  endfunction

  task automatic drive(input logic [10:0] s);
    {bus.data_ena, bus.sop, bus.full_flag, bus.data_in} = s;
    @(posedge clk_50);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(sv(0, 0, 0, 8'h00));
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(sv(1, 1, 0, 8'hFF));
    drive(sv(1, 0, 0, 8'hEE));
    total++;
    if (obs !== 14'h0000) begin
      bad++;
      $display("FAIL reset: got=%h exp=%h", obs, 14'h0000);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [10:0] s [5];
    logic [13:0] e [5];
    s = '{sv(1,1,0,8'hA0), sv(1,0,0,8'hA1), sv(1,0,0,8'hA2), sv(1,0,0,8'hA3), sv(0,0,0,8'h00)};
    e = '{ev(1,8'hA0,1,0,0,0), ev(1,8'hA1,2,0,0,0), ev(1,8'hA2,3,0,0,0), ev(1,8'hA3,0,1,0,0),
          ev(0,8'h00,0,0,0,0)};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      total++;
      if ((obs & msk(e[i])) !== (e[i] & msk(e[i]))) begin
        bad++;
        $display("FAIL stream step %0d: got=%h exp=%h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [10:0] s [7];
    logic [13:0] e [7];
    s = '{sv(1,1,0,8'h10), sv(1,1,1,8'h11), sv(0,0,1,8'h00), sv(0,0,1,8'h00), sv(0,0,0,8'h00),
          sv(1,0,0,8'h12), sv(0,0,0,8'h00)};
    e = '{ev(1,8'h10,1,0,0,0), ev(0,8'h00,1,0,0,0), ev(0,8'h00,1,0,0,0), ev(0,8'h00,1,0,0,0),
          ev(1,8'h11,1,0,0,1), ev(1,8'h12,2,0,0,1), ev(0,8'h00,2,0,0,1)};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(s[i]);
      total++;
      if ((obs & msk(e[i])) !== (e[i] & msk(e[i]))) begin
        bad++;
        $display("FAIL stall step %0d: got=%h exp=%h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [10:0] s [4];
    logic [13:0] e [4];
    s = '{sv(1,1,1,8'h21), sv(1,0,1,8'h22), sv(0,0,0,8'h00), sv(0,0,0,8'h00)};
    e = '{ev(0,8'h00,0,0,0,0), ev(0,8'h00,0,0,1,0), ev(1,8'h21,1,0,1,0), ev(0,8'h00,1,0,1,0)};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      total++;
      if ((obs & msk(e[i])) !== (e[i] & msk(e[i]))) begin
        bad++;
        $display("FAIL overflow step %0d: got=%h exp=%h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] s [4];
    logic [13:0] e [4];
    s = '{sv(1,1,1,8'h31), sv(1,0,0,8'h32), sv(0,0,0,8'h00), sv(0,0,0,8'h00)};
    e = '{ev(0,8'h00,0,0,0,0), ev(1,8'h31,1,0,0,0), ev(1,8'h32,2,0,0,0), ev(0,8'h00,2,0,0,0)};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      total++;
      if ((obs & msk(e[i])) !== (e[i] & msk(e[i]))) begin
        bad++;
        $display("FAIL back_to_back step %0d: got=%h exp=%h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_misalign();
    logic [10:0] s [6];
    logic [13:0] e [6];
    s = '{sv(1,1,0,8'h40), sv(1,0,0,8'h41), sv(1,1,0,8'h50), sv(1,0,0,8'h51), sv(1,0,0,8'h52),
          sv(1,0,0,8'h53)};
    e = '{ev(1,8'h40,1,0,0,0), ev(1,8'h41,2,0,0,0), ev(1,8'h50,1,0,0,1), ev(1,8'h51,2,0,0,1),
          ev(1,8'h52,3,0,0,1), ev(1,8'h53,0,1,0,1)};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(s[i]);
      total++;
      if ((obs & msk(e[i])) !== (e[i] & msk(e[i]))) begin
        bad++;
        $display("FAIL misalign step %0d: got=%h exp=%h", i, obs, e[i]);
      end
    end
  endtask

  // Runs directly after test_misalign: a reset pulse that misses every edge must leave pkt_err set.
  task automatic test_reset_glitch();
    logic [13:0] e;
    e = ev(0, 8'h00, 0, 0, 0, 1);
    {bus.data_ena, bus.sop, bus.full_flag, bus.data_in} = sv(0, 0, 0, 8'h00);
    #3 reset_n = 1'b0;
    #4 reset_n = 1'b1;
    @(posedge clk_50);
    #1;
    total++;
    if ((obs & msk(e)) !== (e & msk(e))) begin
      bad++;
      $display("FAIL reset_glitch: got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_mid_reset();
    logic [10:0] s [5];
    logic [13:0] e [5];
    logic        r [5];
    s = '{sv(1,1,1,8'h61), sv(1,0,1,8'h62), sv(1,1,0,8'h70), sv(0,0,0,8'h00), sv(0,0,0,8'h00)};
    e = '{ev(0,8'h00,0,0,0,0), ev(0,8'h00,0,0,1,0), 14'h0000, 14'h0000, 14'h0000};
    r = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      reset_n = r[i];
      drive(s[i]);
      total++;
      if ((obs & (i >= 2 ? 14'h3FFF : msk(e[i]))) !== (e[i] & (i >= 2 ? 14'h3FFF : msk(e[i])))) begin
        bad++;
        $display("FAIL mid_reset step %0d: got=%h exp=%h", i, obs, e[i]);
      end
    end
  endtask

  initial begin
    {bus.data_ena, bus.sop, bus.full_flag, bus.data_in} = sv(0, 0, 0, 8'h00);
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_overflow();
    test_back_to_back();
    test_misalign();
    test_reset_glitch();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
